// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: sole master of the 16-bit address / 8-bit data memory bus, one request at a time.
// Optional MEM_BUS_ERR_EN rejects addresses at or above IO_BASE+IO_SIZE with a rsp_err response.
module mem_bus_ctrl #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [15:0] IO_BASE     = 16'h8000,
  parameter int unsigned IO_SIZE     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_ce,
  output logic        mem_r,
  output logic        mem_w,
  output logic        mem_oe
);

  if (WAIT_CYCLES > 15 || 32'(IO_BASE) + IO_SIZE > 32'h10000) begin : g_bad_cfg
    $error("mem_bus_ctrl: WAIT_CYCLES must be 0..15 and the IO window must fit below 64K");
  end

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_WAIT,
    ST_CAPT,
`ifdef MEM_BUS_ERR_EN
    ST_ERR,
`endif
    ST_RESP
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] wait_cnt, cnt_nxt;
  logic       accept;
  logic       addr_bad;

`ifdef MEM_BUS_ERR_EN
  localparam logic [16:0] IO_LIMIT = 17'(IO_BASE) + 17'(IO_SIZE);
  assign addr_bad = ({1'b0, req_addr} >= IO_LIMIT);
`else
  assign addr_bad = 1'b0;
`endif

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_ready && req_valid;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = wait_cnt;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
`ifdef MEM_BUS_ERR_EN
          if (addr_bad)    state_nxt = ST_ERR;
          else if (req_we) state_nxt = ST_WR;
          else             state_nxt = ST_RD;
`else
          state_nxt = req_we ? ST_WR : ST_RD;
`endif
        end
      end
      ST_WR: state_nxt = ST_RESP;
      ST_RD: begin
        if (WAIT_CYCLES > 0) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = WAIT_LOAD;
        end else begin
          state_nxt = ST_CAPT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 4'd0) state_nxt = ST_CAPT;
        else                  cnt_nxt   = wait_cnt - 4'd1;
      end
      ST_CAPT: state_nxt = ST_RESP;
`ifdef MEM_BUS_ERR_EN
      ST_ERR:  state_nxt = ST_RESP;
`endif
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so each one lines up with its state cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
      mem_ce    <= 1'b0;
      mem_r     <= 1'b0;
      mem_w     <= 1'b0;
      mem_oe    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
    end else begin
      state    <= state_nxt;
      wait_cnt <= cnt_nxt;
      if (accept) begin
        mem_addr  <= req_addr;
        mem_wdata <= req_wdata;
      end
      mem_ce    <= (state_nxt inside {ST_WR, ST_RD, ST_WAIT, ST_CAPT});
      mem_w     <= (state_nxt == ST_WR);
      mem_r     <= (state_nxt == ST_RD);
      mem_oe    <= (state_nxt inside {ST_WAIT, ST_CAPT});
      rsp_valid <= (state_nxt == ST_RESP);
      if (state == ST_CAPT) rsp_rdata <= mem_rdata;
    end
  end

`ifdef MEM_BUS_ERR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rsp_err <= 1'b0;
    else      rsp_err <= (state == ST_ERR) && (state_nxt == ST_RESP);
  end
`else
  logic unused_addr_bad;
  assign unused_addr_bad = addr_bad;
  assign rsp_err = 1'b0;
`endif

endmodule
